// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl
//   Load/store front end between the core's memory stage and the on-chip
//   1 KB byte-lane RAM. Takes one request at a time. It checks alignment and
//   address range, builds the active-low byte write mask, replicates store
//   data across lanes, and extends load data. Each request ends with a
//   one-cycle done pulse.
//
// State table:
//   state         | meaning
//   IDLE          | ready for a request; req_ready = 1
//   READ_WAIT     | load address presented, RAM registering read data
//   READ_CAPTURE  | RAM read data valid, extract/extend and signal done
//   WRITE         | write strobe high for exactly this cycle, signal done
//   FAULT         | rejected request, signal done with error
//
// Ports:
//   clk, reset         system clock, asynchronous active-low reset
//   req_*              core request (valid/ready handshake, accepted in IDLE)
//   done, error        one-cycle completion pulse and fault flag
//   load_data          extended load result, held until the next done
//   ram_*              RAM interface: byte address, lane data, active-low
//                      lane mask, write strobe, registered read data
module mem_bus_ctrl #(
    parameter logic [31:0] RAM_BASE      = 32'h0000_4000,
    parameter int          RAM_ADDR_BITS = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [1:0]               req_size,
    input  logic                     req_unsigned,
    input  logic [31:0]              req_address,
    input  logic [31:0]              req_wdata,
    output logic                     done,
    output logic                     error,
    output logic [31:0]              load_data,
    output logic [RAM_ADDR_BITS-1:0] ram_address,
    output logic [31:0]              ram_data_in,
    input  logic [31:0]              ram_data_out,
    output logic [3:0]               ram_write_mask,
    output logic                     ram_write_enable
);

    typedef enum logic [2:0] {
        IDLE,
        READ_WAIT,
        READ_CAPTURE,
        WRITE,
        FAULT
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    state_t state, state_nx;

    logic [1:0]               size_q, size_nx;
    logic [1:0]               offset_q, offset_nx;
    logic                     unsigned_q, unsigned_nx;
    logic [RAM_ADDR_BITS-1:0] ram_address_nx;
    logic [31:0]              ram_data_in_nx;
    logic [3:0]               ram_write_mask_nx;
    logic                     ram_write_enable_nx;
    logic                     done_nx;
    logic                     error_nx;
    logic [31:0]              load_data_nx;

    logic [1:0]  req_offset;
    logic        req_fault;
    logic [3:0]  store_mask;
    logic [31:0] store_data;
    logic [31:0] load_extracted;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    assign req_ready  = (state == IDLE);
    assign req_offset = req_address[1:0];

    // Fault: illegal size, misalignment, or address outside the RAM window.
    always_comb begin
        req_fault = 1'b0;
        if (req_size == 2'd3)
            req_fault = 1'b1;
        if (req_size == SIZE_HALF && req_offset[0])
            req_fault = 1'b1;
        if (req_size == SIZE_WORD && req_offset != 2'd0)
            req_fault = 1'b1;
        if (req_address[31:RAM_ADDR_BITS] != RAM_BASE[31:RAM_ADDR_BITS])
            req_fault = 1'b1;
    end

    always_comb begin
        store_mask = 4'b0000;
        store_data = req_wdata;
        case (req_size)
            SIZE_BYTE: begin
                store_mask = ~(4'b0001 << req_offset);
                store_data = {4{req_wdata[7:0]}};
            end
            SIZE_HALF: begin
                store_mask = req_offset[1] ? 4'b0011 : 4'b1100;
                store_data = {2{req_wdata[15:0]}};
            end
            default: begin
                store_mask = 4'b0000;
                store_data = req_wdata;
            end
        endcase
    end

    always_comb begin
        load_byte = ram_data_out[7:0];
        case (offset_q)
            2'd0:    load_byte = ram_data_out[7:0];
            2'd1:    load_byte = ram_data_out[15:8];
            2'd2:    load_byte = ram_data_out[23:16];
            default: load_byte = ram_data_out[31:24];
        endcase
        load_half = offset_q[1] ? ram_data_out[31:16] : ram_data_out[15:0];
        case (size_q)
            SIZE_BYTE: load_extracted = {{24{~unsigned_q & load_byte[7]}}, load_byte};
            SIZE_HALF: load_extracted = {{16{~unsigned_q & load_half[15]}}, load_half};
            default:   load_extracted = ram_data_out;
        endcase
    end

    always_comb begin
        state_nx            = state;
        size_nx             = size_q;
        offset_nx           = offset_q;
        unsigned_nx         = unsigned_q;
        ram_address_nx      = ram_address;
        ram_data_in_nx      = ram_data_in;
        ram_write_mask_nx   = 4'b1111;
        ram_write_enable_nx = 1'b0;
        done_nx             = 1'b0;
        error_nx            = 1'b0;
        load_data_nx        = load_data;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    size_nx        = req_size;
                    offset_nx      = req_offset;
                    unsigned_nx    = req_unsigned;
                    ram_address_nx = req_address[RAM_ADDR_BITS-1:0];
                    if (req_fault) begin
                        state_nx = FAULT;
                    end else if (req_write) begin
                        state_nx            = WRITE;
                        ram_write_enable_nx = 1'b1;
                        ram_write_mask_nx   = store_mask;
                        ram_data_in_nx      = store_data;
                    end else begin
                        state_nx = READ_WAIT;
                    end
                end
            end
            WRITE: begin
                done_nx  = 1'b1;
                state_nx = IDLE;
            end
            READ_WAIT: begin
                state_nx = READ_CAPTURE;
            end
            READ_CAPTURE: begin
                load_data_nx = load_extracted;
                done_nx      = 1'b1;
                state_nx     = IDLE;
            end
            FAULT: begin
                load_data_nx = 32'h0;
                done_nx      = 1'b1;
                error_nx     = 1'b1;
                state_nx     = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Async reset on the strobe drops a pending write immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            size_q           <= 2'd0;
            offset_q         <= 2'd0;
            unsigned_q       <= 1'b0;
            ram_address      <= '0;
            ram_data_in      <= 32'h0;
            ram_write_mask   <= 4'b1111;
            ram_write_enable <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
            load_data        <= 32'h0;
        end else begin
            size_q           <= size_nx;
            offset_q         <= offset_nx;
            unsigned_q       <= unsigned_nx;
            ram_address      <= ram_address_nx;
            ram_data_in      <= ram_data_in_nx;
            ram_write_mask   <= ram_write_mask_nx;
            ram_write_enable <= ram_write_enable_nx;
            done             <= done_nx;
            error            <= error_nx;
            load_data        <= load_data_nx;
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl
//   Directed bench for mem_bus_ctrl with a byte-lane RAM model that has
//   registered read data. Expected values are hand-computed constants.
module tb_mem_bus_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic        done;
    logic        error;
    logic [31:0] load_data;
    logic [9:0]  ram_address;
    logic [31:0] ram_data_in;
    logic [31:0] ram_data_out;
    logic [3:0]  ram_write_mask;
    logic        ram_write_enable;

    int n_tests = 0;
    int n_fail  = 0;

    // Values captured by issue() for the caller to check.
    int          lat_o;
    logic [31:0] ld_o;
    logic        err_o;
    logic        we_o;
    logic [3:0]  mask_o;
    logic [31:0] din_o;

    logic [31:0] mem [0:255];

    mem_bus_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_unsigned     (req_unsigned),
        .req_address      (req_address),
        .req_wdata        (req_wdata),
        .done             (done),
        .error            (error),
        .load_data        (load_data),
        .ram_address      (ram_address),
        .ram_data_in      (ram_data_in),
        .ram_data_out     (ram_data_out),
        .ram_write_mask   (ram_write_mask),
        .ram_write_enable (ram_write_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_write_enable) begin
            for (int k = 0; k < 4; k++)
                if (!ram_write_mask[k])
                    mem[ram_address[9:2]][8*k +: 8] <= ram_data_in[8*k +: 8];
        end
        ram_data_out <= mem[ram_address[9:2]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request from IDLE; records latency from acceptance to done, the
    // result, and the RAM strobe/mask/data seen one step after acceptance.
    // Write strobe is also watched during the wait for done.
    task automatic issue(input string tag, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_address  = addr;
        req_wdata    = wd;
        req_valid    = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        we_o   = ram_write_enable;
        mask_o = ram_write_mask;
        din_o  = ram_data_in;
        lat_o  = 0;
        while (!done && lat_o < 8) begin
            @(posedge clk);
            #1;
            lat_o++;
            if (ram_write_enable) we_o = 1'b1;
        end
        if (!done) chk({tag, "_timeout"}, 32'(done), 32'd1);
        ld_o  = load_data;
        err_o = error;
    endtask

    task automatic check_fault(input string tag);
        chk({tag, "_lat"}, 32'(lat_o), 32'd1);
        chk({tag, "_err"}, 32'(err_o), 32'd1);
        chk({tag, "_ld"},  ld_o, 32'h0);
        chk({tag, "_we"},  32'(we_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_address  = 32'h0;
        req_wdata    = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_we",    32'(ram_write_enable), 32'd0);
        chk("rst_mask",  32'(ram_write_mask), 32'hF);
        chk("rst_addr",  32'(ram_address), 32'h0);
        chk("rst_din",   ram_data_in, 32'h0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_err",   32'(error), 32'd0);
        chk("rst_ld",    load_data, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Word store then load
        issue("sw", 1'b1, 2'd2, 1'b0, 32'h0000_4010, 32'hDEAD_BEEF);
        chk("sw_we",   32'(we_o), 32'd1);
        chk("sw_mask", 32'(mask_o), 32'h0);
        chk("sw_din",  din_o, 32'hDEAD_BEEF);
        chk("sw_lat",  32'(lat_o), 32'd1);
        chk("sw_err",  32'(err_o), 32'd0);
        chk("sw_ld_unchanged", ld_o, 32'h0);
        chk("sw_we_off", 32'(ram_write_enable), 32'd0);
        chk("sw_mask_off", 32'(ram_write_mask), 32'hF);
        @(posedge clk);
        #1;
        chk("sw_done_1cyc", 32'(done), 32'd0);

        issue("lw", 1'b0, 2'd2, 1'b0, 32'h0000_4010, 32'h0);
        chk("lw_lat",  32'(lat_o), 32'd2);
        chk("lw_data", ld_o, 32'hDEAD_BEEF);
        chk("lw_err",  32'(err_o), 32'd0);
        chk("lw_we",   32'(we_o), 32'd0);
        @(posedge clk);
        #1;
        chk("lw_done_1cyc", 32'(done), 32'd0);
        chk("lw_ld_held", load_data, 32'hDEAD_BEEF);

        // Byte store to lane 3
        issue("sb", 1'b1, 2'd0, 1'b0, 32'h0000_4013, 32'h1234_5680);
        chk("sb_mask", 32'(mask_o), 32'h7);
        chk("sb_din",  din_o, 32'h8080_8080);
        chk("sb_ld_unchanged", ld_o, 32'hDEAD_BEEF);
        issue("lb", 1'b0, 2'd0, 1'b0, 32'h0000_4013, 32'h0);
        chk("lb_data", ld_o, 32'hFFFF_FF80);
        issue("lbu", 1'b0, 2'd0, 1'b1, 32'h0000_4013, 32'h0);
        chk("lbu_data", ld_o, 32'h0000_0080);
        issue("lw_merge", 1'b0, 2'd2, 1'b0, 32'h0000_4010, 32'h0);
        chk("lw_merge_data", ld_o, 32'h80AD_BEEF);
        issue("lbu1", 1'b0, 2'd0, 1'b1, 32'h0000_4011, 32'h0);
        chk("lbu1_data", ld_o, 32'h0000_00BE);

        // Halfword store to upper half
        issue("sh", 1'b1, 2'd1, 1'b0, 32'h0000_4022, 32'hABCD_8001);
        chk("sh_mask", 32'(mask_o), 32'h3);
        chk("sh_din",  din_o, 32'h8001_8001);
        issue("lh", 1'b0, 2'd1, 1'b0, 32'h0000_4022, 32'h0);
        chk("lh_data", ld_o, 32'hFFFF_8001);
        chk("lh_lat",  32'(lat_o), 32'd2);
        issue("lhu", 1'b0, 2'd1, 1'b1, 32'h0000_4022, 32'h0);
        chk("lhu_data", ld_o, 32'h0000_8001);
        issue("sh0", 1'b1, 2'd1, 1'b0, 32'h0000_4020, 32'h0000_7F02);
        chk("sh0_mask", 32'(mask_o), 32'hC);
        issue("lw_h", 1'b0, 2'd2, 1'b0, 32'h0000_4020, 32'h0);
        chk("lw_h_data", ld_o, 32'h8001_7F02);

        // Faults
        issue("f_sw_mis", 1'b1, 2'd2, 1'b0, 32'h0000_4011, 32'h1111_1111);
        check_fault("f_sw_mis");
        issue("lw_ok", 1'b0, 2'd2, 1'b0, 32'h0000_4010, 32'h0);
        chk("lw_ok_data", ld_o, 32'h80AD_BEEF);
        chk("lw_ok_err",  32'(err_o), 32'd0);
        issue("f_lh_mis", 1'b0, 2'd1, 1'b0, 32'h0000_4005, 32'h0);
        check_fault("f_lh_mis");
        issue("lw_ok2", 1'b0, 2'd2, 1'b0, 32'h0000_4010, 32'h0);
        issue("f_range", 1'b0, 2'd2, 1'b0, 32'h0000_4400, 32'h0);
        check_fault("f_range");
        issue("lw_ok3", 1'b0, 2'd2, 1'b0, 32'h0000_4010, 32'h0);
        issue("f_size3", 1'b1, 2'd3, 1'b0, 32'h0000_4010, 32'h2222_2222);
        check_fault("f_size3");
        issue("lw_after", 1'b0, 2'd2, 1'b0, 32'h0000_4010, 32'h0);
        chk("lw_after_data", ld_o, 32'h80AD_BEEF);

        // Reset mid-store
        issue("sw_pre", 1'b1, 2'd2, 1'b0, 32'h0000_4030, 32'h55AA_55AA);
        @(negedge clk);
        req_write   = 1'b1;
        req_size    = 2'd2;
        req_address = 32'h0000_4030;
        req_wdata   = 32'h1122_3344;
        req_valid   = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("mid_we_high", 32'(ram_write_enable), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_we_drop", 32'(ram_write_enable), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_ready", 32'(req_ready), 32'd1);
        chk("mid_mask",  32'(ram_write_mask), 32'hF);
        chk("mid_done",  32'(done), 32'd0);
        issue("mid_lw", 1'b0, 2'd2, 1'b0, 32'h0000_4030, 32'h0);
        chk("mid_lw_data", ld_o, 32'h55AA_55AA);

        // Back-to-back with req_valid held high
        @(negedge clk);
        chk("b2b_ready0", 32'(req_ready), 32'd1);
        req_write   = 1'b1;
        req_size    = 2'd2;
        req_address = 32'h0000_4040;
        req_wdata   = 32'h0BAD_F00D;
        req_valid   = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_st1_we", 32'(ram_write_enable), 32'd1);
        req_write = 1'b0;
        @(posedge clk);
        #1;
        chk("b2b_st1_done",  32'(done), 32'd1);
        chk("b2b_st1_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("b2b_ld_acc",  32'(req_ready), 32'd0);
        chk("b2b_ld_done0", 32'(done), 32'd0);
        req_write = 1'b1;
        req_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        chk("b2b_busy_done", 32'(done), 32'd0);
        chk("b2b_busy_we",   32'(ram_write_enable), 32'd0);
        @(posedge clk);
        #1;
        chk("b2b_ld_done", 32'(done), 32'd1);
        chk("b2b_ld_data", load_data, 32'h0BAD_F00D);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("b2b_st2_we",  32'(ram_write_enable), 32'd1);
        chk("b2b_st2_din", ram_data_in, 32'hCAFE_F00D);
        @(posedge clk);
        #1;
        chk("b2b_st2_done", 32'(done), 32'd1);
        issue("b2b_lw", 1'b0, 2'd2, 1'b0, 32'h0000_4040, 32'h0);
        chk("b2b_lw_data", ld_o, 32'hCAFE_F00D);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
